// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads 16-bit words over a
// req/ready handshake and hands each one to the instruction register with a one-cycle strobe.
module instruction_fetch_unit #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned TIMEOUT  = 8    // must be >= 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              start,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ir_data,
   output logic              ir_w,
   input  logic              next,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic              halt,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              fault
);

   localparam int unsigned       CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_LOAD,
      S_WAIT,
      S_HALTED
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                fault_q, fault_d;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         pc_q    <= ADDR_W'(RESET_PC);
         ir_q    <= '0;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   // NOTE: every variable gets a hold-value default up front so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end

         S_REQ: begin
            if (mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + ADDR_W'(1);
               cnt_d   = '0;
               state_d = S_LOAD;
            end else if (cnt_q == CNT_LAST) begin
               // TIMEOUT consecutive unanswered request cycles
               fault_d = 1'b1;
               state_d = S_HALTED;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_LOAD: state_d = S_WAIT;

         S_WAIT: begin
            if (halt) begin
               state_d = S_HALTED;
            end else if (branch_taken) begin
               pc_d    = branch_addr;
               cnt_d   = '0;
               state_d = S_REQ;
            end else if (next) begin
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end

         S_HALTED: state_d = S_HALTED;

         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req  = (state_q == S_REQ);
      ir_w     = (state_q == S_LOAD);
      busy     = (state_q == S_REQ) || (state_q == S_LOAD);
      mem_addr = pc_q;
      pc       = pc_q;
      ir_data  = ir_q;
      fault    = fault_q;
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized
// fetch transactions checked against a transaction-level PC/IR model.
module tb_instruction_fetch_unit;

   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 8;

   localparam int K_NEXT   = 0;
   localparam int K_BRANCH = 1;
   localparam int K_START  = 2;
   localparam int K_BR_NXT = 3;

   logic              CLK = 1'b0;
   logic              RESET;
   logic              start;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] ir_data;
   logic              ir_w;
   logic              next;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_addr;
   logic              halt;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              fault;

   int errors = 0;
   int checks = 0;

   // transaction-level reference state
   int model_pc = 0;
   int model_ir = 0;

   instruction_fetch_unit #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK(CLK), .RESET(RESET), .start(start),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .ir_data(ir_data), .ir_w(ir_w), .next(next), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .halt(halt), .pc(pc), .busy(busy), .fault(fault)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One complete fetch from WAIT (or IDLE for K_START), ending two cycles into WAIT.
   task automatic fetch(input int kind, input logic [ADDR_W-1:0] baddr, input int waits,
                        input logic [DATA_W-1:0] data, input bit next_in_load, input string tag);
      int target;
      target = (kind == K_BRANCH || kind == K_BR_NXT) ? int'(baddr) : model_pc;
      case (kind)
         K_NEXT:   next = 1'b1;
         K_BRANCH: begin branch_taken = 1'b1; branch_addr = baddr; end
         K_BR_NXT: begin branch_taken = 1'b1; branch_addr = baddr; next = 1'b1; end
         default:  start = 1'b1;
      endcase
      tick();
      next = 1'b0; branch_taken = 1'b0; start = 1'b0;
      branch_addr = ADDR_W'($urandom);
      for (int i = 0; i < waits; i++) begin
         check({tag, ".req_wait"}, mem_req, 1'b1);
         check({tag, ".addr_wait"}, mem_addr, target);
         mem_ready = 1'b0;
         mem_rdata = DATA_W'($urandom);
         tick();
      end
      check({tag, ".req"}, mem_req, 1'b1);
      check({tag, ".addr"}, mem_addr, target);
      check({tag, ".fault_req"}, fault, 1'b0);
      mem_ready = 1'b1;
      mem_rdata = data;
      tick();
      model_pc = (target + 1) % (1 << ADDR_W);
      model_ir = int'(data);
      check({tag, ".ir_w_load"}, ir_w, 1'b1);
      check({tag, ".ir_data_load"}, ir_data, model_ir);
      check({tag, ".pc_load"}, pc, model_pc);
      check({tag, ".busy_load"}, busy, 1'b1);
      check({tag, ".req_load"}, mem_req, 1'b0);
      mem_ready = 1'b0;
      mem_rdata = DATA_W'($urandom);
      if (next_in_load) next = 1'b1;
      tick();
      next = 1'b0;
      check({tag, ".ir_w_wait"}, ir_w, 1'b0);
      check({tag, ".busy_wait"}, busy, 1'b0);
      check({tag, ".ir_data_wait"}, ir_data, model_ir);
      tick();
      check({tag, ".idle_wait"}, mem_req, 1'b0);
      check({tag, ".pc_wait"}, pc, model_pc);
      check({tag, ".fault_wait"}, fault, 1'b0);
   endtask

   initial begin
      RESET = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      next = 1'b0; branch_taken = 1'b0; branch_addr = '0; halt = 1'b0;
      #2;
      check("rst.pc", pc, 0);
      check("rst.req", mem_req, 1'b0);
      check("rst.busy", busy, 1'b0);
      check("rst.fault", fault, 1'b0);
      tick();
      RESET = 1'b0;

      // Reset asserted mid-REQ aborts the fetch immediately
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      mem_rdata = 16'h6AB3;
      check("rmid.req", mem_req, 1'b1);
      tick();
      RESET = 1'b1;
      #1;
      check("rmid.pc", pc, 0);
      check("rmid.ir_data", ir_data, 0);
      check("rmid.ir_w", ir_w, 1'b0);
      check("rmid.req", mem_req, 1'b0);
      check("rmid.busy", busy, 1'b0);
      check("rmid.fault", fault, 1'b0);
      tick();
      RESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle.req", mem_req, 1'b0);
         check("idle.busy", busy, 1'b0);
      end
      model_pc = 0;
      model_ir = 0;

      // Basic, wait-state and LOAD-ignores-next fetches
      fetch(K_START, '0, 0, 16'h6AB3, 1'b0, "basic");
      fetch(K_NEXT, '0, 3, 16'h16F4, 1'b1, "seq");
      check("seq.pc2", pc, 2);

      // Branch beats next; PC lands one past the target
      fetch(K_BR_NXT, 10'h2B3, 1, 16'hBEEF, 1'b0, "brpri");
      check("brpri.pc", pc, 10'h2B4);

      // Wrap-around at the top of the address space
      fetch(K_BRANCH, 10'h3FF, 0, 16'h1234, 1'b0, "wrap");
      check("wrap.pc0", pc, 0);
      fetch(K_NEXT, '0, 0, 16'h5678, 1'b0, "wrapnext");

      // Randomized fetch sequence
      for (int n = 0; n < 24; n++) begin
         int kind;
         int idle;
         kind = ($urandom_range(0, 2) == 0) ? K_BRANCH : K_NEXT;
         fetch(kind, ADDR_W'($urandom), int'($urandom_range(0, TIMEOUT - 3)),
               DATA_W'($urandom), 1'($urandom_range(0, 1)), "rnd");
         idle = int'($urandom_range(0, 2));
         for (int i = 0; i < idle; i++) begin
            tick();
            check("rnd.hold_req", mem_req, 1'b0);
            check("rnd.hold_ir", ir_data, model_ir);
         end
      end

      // Halt wins over branch and next, and HALTED ignores everything
      halt = 1'b1; branch_taken = 1'b1; branch_addr = 10'h2B3; next = 1'b1;
      tick();
      halt = 1'b0; branch_taken = 1'b0; next = 1'b0;
      check("halt.req", mem_req, 1'b0);
      check("halt.busy", busy, 1'b0);
      check("halt.pc", pc, model_pc);
      for (int i = 0; i < 3; i++) begin
         start = 1'b1; next = 1'b1; branch_taken = 1'b1;
         tick();
         check("halt.sticky_req", mem_req, 1'b0);
         check("halt.sticky_pc", pc, model_pc);
      end
      start = 1'b0; next = 1'b0; branch_taken = 1'b0;

      // Timeout: TIMEOUT unanswered REQ cycles then sticky fault
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      mem_ready = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         check("tmo.req", mem_req, 1'b1);
         check("tmo.fault_early", fault, 1'b0);
         check("tmo.ir_w", ir_w, 1'b0);
         tick();
      end
      check("tmo.fault", fault, 1'b1);
      check("tmo.req_drop", mem_req, 1'b0);
      check("tmo.busy", busy, 1'b0);
      for (int i = 0; i < 4; i++) begin
         start = 1'b1; next = 1'b1;
         tick();
         check("tmo.sticky_fault", fault, 1'b1);
         check("tmo.sticky_req", mem_req, 1'b0);
         check("tmo.sticky_ir_w", ir_w, 1'b0);
      end
      start = 1'b0; next = 1'b0;
      RESET = 1'b1;
      #1;
      check("tmo.reset_clears", fault, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the instruction register.
- Holds the program counter and fetches 16-bit instruction words from program memory over a req/ready handshake.
- Presents each fetched word to the instruction register's `in` port with a one-cycle write strobe (`w`).
- Waits for the control unit to request the next sequential fetch, redirect to a branch address, or halt. Detects memory timeouts.

Parameters:
- ADDR_W, 10: program address width; matches the 10-bit BA branch field.
- DATA_W, 16: instruction word width.
- RESET_PC, 0: PC value after reset.
- TIMEOUT, 8: maximum consecutive REQ cycles without mem_ready before fault; must be ≥ 2.

Ports:
- CLK  in  1: clock, rising edge.
- RESET  in  1: asynchronous, active-high reset.
- start  in  1: leave IDLE and begin fetching.
- mem_req  out  1: read request to program memory.
- mem_addr  out  ADDR_W: read address; always equals pc.
- mem_ready  in  1: memory data valid this cycle.
- mem_rdata  in  DATA_W: memory read data.
- ir_data  out  DATA_W: captured instruction; drives the instruction register's `in`.
- ir_w  out  1: one-cycle write strobe; drives the instruction register's `w`.
- next  in  1: control unit requests the sequential fetch.
- branch_taken  in  1: control unit redirects fetch.
- branch_addr  in  ADDR_W: branch target (BA field).
- halt  in  1: stop fetching.
- pc  out  ADDR_W: current program counter.
- busy  out  1: high in REQ or LOAD.
- fault  out  1: sticky memory-timeout flag.

Behaviour:
- Reset values (async, immediate): state=IDLE, pc=RESET_PC, ir_data=0, ir_w=0, mem_req=0, busy=0, fault=0, timeout counter=0. Reset mid-fetch aborts the fetch; no ir_w is issued.
- Moore outputs: mem_req=1 only in REQ; ir_w=1 only in LOAD; busy=1 in REQ or LOAD; mem_addr=pc combinationally.
- States and transitions:
  - IDLE: start=1 -> REQ. Otherwise stay.
  - REQ: if mem_ready=1, capture mem_rdata into ir_data, set pc<=pc+1 (wraps 2^ADDR_W-1 -> 0), clear counter, go to LOAD. Otherwise increment counter; when counter reaches TIMEOUT-1 and mem_ready=0, set fault=1 and go to HALTED. The counter is cleared on every entry to REQ.
  - LOAD: exactly one cycle with ir_w=1, then -> WAIT. ir_data is stable through LOAD and WAIT, so the IR captures it at the LOAD->WAIT edge.
  - WAIT: priority is halt > branch_taken > next.
    - halt -> HALTED.
    - branch_taken -> pc<=branch_addr, go to REQ.
    - next -> REQ with pc unchanged (already incremented).
    - None asserted: stay.
  - HALTED: sticky until RESET; all inputs ignored.
- next, branch_taken and halt are sampled only in WAIT; they are ignored in IDLE, REQ and LOAD. mem_rdata is sampled only when mem_req and mem_ready are both high.
- Latency: start sampled at edge E. mem_req is high after E. With mem_ready high in that cycle, ir_w is high after E+1 and the IR is loaded at E+2. A fetch back-to-back from next (WAIT->REQ->LOAD) takes 2 cycles.
- ir_data holds its last value in all states except at the REQ capture edge.
- fault clears only on RESET.

Test Plan:
- Reset check: RESET=1 mid-REQ with mem_rdata=16'h6AB3 -> immediately pc=0, ir_data=0, ir_w=0, mem_req=0, fault=0. With RESET=0 and start=0, the unit stays IDLE.
- Basic fetch: start=1 pulse, mem_ready tied high, mem_rdata=16'h6AB3 (0110101010110011) -> mem_req for 1 cycle at mem_addr=0; ir_w high for exactly 1 cycle with ir_data=16'h6AB3; pc=1; state WAIT, busy=0.
- Sequential fetch with wait states: in WAIT, mem_ready delayed 3 cycles, next=1, mem_rdata=16'h16F4 -> mem_req held 4 cycles at mem_addr=1; ir_data=16'h16F4; pc=2; no fault. Asserting next in LOAD does not start an extra fetch.
- Branch priority: in WAIT, assert next=1, branch_taken=1, branch_addr=10'h2B3 in the same cycle -> mem_addr=10'h2B3 and pc becomes 10'h2B4 after the fetch. With halt=1 also asserted in the same cycle -> HALTED, no mem_req.
- Wrap-around: branch to 10'h3FF, then fetch -> pc=10'h000. The following next fetch reads address 0.
- Timeout: mem_ready held 0 in REQ -> after exactly TIMEOUT(8) REQ cycles, fault=1 and state HALTED. mem_req drops, ir_w is never pulsed, and start/next are ignored until RESET.
